fir_output_stage: RTL and testbench
===================================

Name: fir_output_stage

Overview:
- Downstream neighbour of fir_main. Consumes the 11-bit unsigned filter result o_y_n and its qualifying valid, and produces the 8-bit output byte driven to uo_out.
- Applies a programmable round-half-up right shift, then saturates to 8 bits.
- Tracks a sticky saturation flag, a saturating overflow counter and a peak-hold value for debug readout on uio pins.
- Fixed 2-cycle pipeline; bubbles propagate untouched.

Parameters:
- IN_W, 11, input sample width (unsigned).
- OUT_W, 8, output sample width (unsigned).
- SHIFT_W, 2, width of shift control; shift range 0..2^SHIFT_W-1.
- CNT_W, 8, width of saturation event counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_y_n  input  IN_W  filter result from fir_main.
- i_valid  input  1  i_y_n qualifier (the s_axis_fir_tvalid path).
- i_shift  input  SHIFT_W  requested right-shift amount.
- i_load_shift  input  1  captures i_shift into the shift register.
- i_clr_stats  input  1  clears o_sat, o_sat_cnt, o_peak.
- o_data  output  OUT_W  scaled, saturated sample.
- o_valid  output  1  o_data qualifier.
- o_sat  output  1  sticky: any saturation since reset/clear.
- o_sat_cnt  output  CNT_W  saturation event count, saturating.
- o_peak  output  OUT_W  maximum o_data since reset/clear.

Behaviour:
- Reset (sync, active-high) values: shift_q=0; both pipeline stages empty; o_data=0, o_valid=0, o_sat=0, o_sat_cnt=0, o_peak=0. Reset overrides every other input in that cycle and discards in-flight samples.
- Shift register: on i_load_shift, shift_q<=i_shift. The new value applies to samples entering stage 1 from the next cycle. Samples already in flight keep the shift they were captured with.
- Stage 1 (cycle N, i_valid=1): compute sum = i_y_n + (shift_q==0 ? 0 : 2^(shift_q-1)) at IN_W+1 bits (no wrap), then r = sum >> shift_q. Register r and v1<=1. When i_valid=0: v1<=0 and r holds its value.
- Stage 2 (cycle N+1, v1=1): if r > 2^OUT_W-1 then o_data<=2^OUT_W-1 and sat event=1; else o_data<=r[OUT_W-1:0]. o_valid<=v1. When v1=0, o_data holds its last value and o_valid=0.
- Latency: o_valid rises 2 cycles after the accepted i_valid. Throughput is 1 sample/cycle. There is no backpressure.
- Sat event with o_valid: o_sat<=1. o_sat_cnt increments and sticks at 2^CNT_W-1 (no wrap).
- Peak: on each output-valid cycle, if the new o_data > o_peak then o_peak<=new o_data.
- i_clr_stats on the same cycle as a valid output: the stats are cleared, then that output is folded in. Result: o_peak = that sample, o_sat = its sat event, o_sat_cnt = 0 or 1.
- i_load_shift together with i_valid in the same cycle: the sample uses the old shift_q.
- Worst case: i_y_n=2047 at shift 3 gives (2047+4)>>3=256, which saturates. The adder must be IN_W+1 bits wide.

Optional Feature:
- Macro FIR_OUT_PEAK_EN.
- Defined: peak-hold register and comparator are built as specified above.
- Undefined: no peak logic is synthesized and o_peak is tied to 0. All other behaviour is unchanged.

Test Plan:
- Reset, shift=0, i_y_n=200 valid for 1 cycle -> o_valid=1 exactly 2 cycles later with o_data=200; o_sat=0, o_peak=200.
- shift=0, i_y_n=300 -> o_data=255, o_sat=1, o_sat_cnt=1. Then i_y_n=100 -> o_data=100, o_sat stays 1, o_peak=255.
- Rounding with load_shift: shift=1, i_y_n=5 -> 3. shift=2, i_y_n=1021 -> 255 with no sat. shift=2, i_y_n=1023 -> 255 with sat. shift=3, i_y_n=2047 -> 255 with sat.
- Shift change in flight: stream 400,400 at shift 0, with i_load_shift(2) in the cycle of the 2nd sample -> outputs 255 (sat), 255 (sat). A 3rd sample of 400 -> 100.
- Counter saturation: 300 saturating valid samples -> o_sat_cnt=255 and holds. i_clr_stats with no valid output -> cnt=0, o_sat=0, o_peak=0.
- Bubbles/reset: alternating i_valid 1,0,1 -> o_valid pattern 1,0,1 delayed 2 cycles, o_data holding through the gap. Assert reset with samples in flight -> o_valid=0 next cycle and all outputs 0.

Source files
------------

// File: rtl/fir_output_stage.sv
// fir_output_stage
//   Output stage behind fir_main. It applies a round-half-up right shift to
//   the 11-bit unsigned filter result, then saturates it to an 8-bit output
//   byte. It also keeps debug statistics: a sticky saturation flag, a
//   saturating event counter and a peak-hold value.
//
//   Optional feature: define FIR_OUT_PEAK_EN to build the peak-hold register
//   and its comparator. When the macro is undefined, o_peak is tied to 0.
//
//   Handshake: valid-only, with no ready and no backpressure. A sample is
//   consumed on every cycle that i_valid is high. o_data carries a new sample
//   only on cycles where o_valid is high; otherwise it holds its last value.
//   The pipeline is fixed at two register stages, and bubbles pass through
//   unchanged.

module fir_output_stage #(
    parameter int IN_W    = 11,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 2,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IN_W-1:0]    i_y_n,
    input  logic               i_valid,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic               i_load_shift,
    input  logic               i_clr_stats,
    output logic [OUT_W-1:0]   o_data,
    output logic               o_valid,
    output logic               o_sat,
    output logic [CNT_W-1:0]   o_sat_cnt,
    output logic [OUT_W-1:0]   o_peak
);

    // The adder is one bit wider than the input so that 2047 + 4 cannot wrap.
    localparam int SUM_W = IN_W + 1;

    localparam logic [SUM_W-1:0] OUT_MAX_WIDE = SUM_W'((1 << OUT_W) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    logic [SHIFT_W-1:0] shift_q;

    // Stage 1 registers: the rounded and shifted value, plus its valid bit.
    logic [SUM_W-1:0]   r_q;
    logic               v1_q;

    // Stage 1 combinational path.
    logic [SUM_W-1:0]   rnd;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   r_next;

    // Stage 2 combinational path.
    logic               sat_ev;
    logic [OUT_W-1:0]   data_next;

    // Statistics after an optional clear, before the current output is folded in.
    logic               sat_base;
    logic [CNT_W-1:0]   cnt_base;

    // Rounding constant is half an LSB of the shifted result: 2^(shift-1), or 0 at shift 0.
    always_comb begin
        rnd    = (SUM_W'(1) << shift_q) >> 1;
        sum    = {1'b0, i_y_n} + rnd;
        r_next = sum >> shift_q;
    end

    // Saturate the stage-1 value to the output width.
    always_comb begin
        sat_ev    = (r_q > OUT_MAX_WIDE);
        data_next = sat_ev ? {OUT_W{1'b1}} : r_q[OUT_W-1:0];
    end

    // A clear in the same cycle as a valid output happens first, then that output is folded in.
    always_comb begin
        sat_base = i_clr_stats ? 1'b0 : o_sat;
        cnt_base = i_clr_stats ? '0 : o_sat_cnt;
    end

    // Shift control register. A new value only affects samples entering stage 1 from the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
        end else if (i_load_shift) begin
            shift_q <= i_shift;
        end
    end

    // Stage 1: capture the rounded and shifted sample. r_q holds its value across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q  <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= i_valid;
            if (i_valid) begin
                r_q <= r_next;
            end
        end
    end

    // Stage 2: saturate to the output width. o_data holds its value across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= v1_q;
            if (v1_q) begin
                o_data <= data_next;
            end
        end
    end

    // Sticky saturation flag and event counter. The counter stops at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_sat     <= 1'b0;
            o_sat_cnt <= '0;
        end else if (v1_q) begin
            o_sat     <= sat_base | sat_ev;
            o_sat_cnt <= (sat_ev && (cnt_base != CNT_MAX)) ? cnt_base + 1'b1 : cnt_base;
        end else if (i_clr_stats) begin
            o_sat     <= 1'b0;
            o_sat_cnt <= '0;
        end
    end

`ifdef FIR_OUT_PEAK_EN
    logic [OUT_W-1:0] peak_base;

    // After an optional clear, the peak restarts from zero.
    always_comb begin
        peak_base = i_clr_stats ? '0 : o_peak;
    end

    // Peak hold: keep the largest output value seen since reset or clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_peak <= '0;
        end else if (v1_q) begin
            o_peak <= (data_next > peak_base) ? data_next : peak_base;
        end else if (i_clr_stats) begin
            o_peak <= '0;
        end
    end
`else
    assign o_peak = '0;
`endif

endmodule

// File: tb/tb_fir_output_stage.sv
// tb_fir_output_stage
//   Bench for fir_output_stage. It runs the directed scenarios first, then a
//   randomized phase. A behavioural model computes each expected output from
//   the plain arithmetic rules. It predicts when each output appears by
//   tagging it with the clock edge on which it is due.

module tb_fir_output_stage;

  localparam int IN_W    = 11;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 2;
  localparam int CNT_W   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [IN_W-1:0]    i_y_n;
  logic               i_valid;
  logic [SHIFT_W-1:0] i_shift;
  logic               i_load_shift;
  logic               i_clr_stats;
  logic [OUT_W-1:0]   o_data;
  logic               o_valid;
  logic               o_sat;
  logic [CNT_W-1:0]   o_sat_cnt;
  logic [OUT_W-1:0]   o_peak;

  fir_output_stage #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_y_n(i_y_n),
    .i_valid(i_valid),
    .i_shift(i_shift),
    .i_load_shift(i_load_shift),
    .i_clr_stats(i_clr_stats),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_sat(o_sat),
    .o_sat_cnt(o_sat_cnt),
    .o_peak(o_peak)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {sat, data}. due_q holds the edge number on which the entry is expected.
  logic [OUT_W:0] exp_q[$];
  int             due_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  // Model state.
  int shift_m = 0;
  int sat_m   = 0;
  int cnt_m   = 0;
  int peak_m  = 0;
  int last_m  = 0;
  int vexp    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
  endtask

  // Reference arithmetic: round half up, shift right, then clip to 255.
  function automatic logic [OUT_W:0] model_out(input int y, input int s);
    int r;
    r = (y + ((s == 0) ? 0 : (1 << (s - 1)))) >> s;
    if (r > 255) return {1'b1, 8'd255};
    return {1'b0, 8'(r)};
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of inputs, advances the model across the edge, then checks every output.
  task automatic step(input logic v, input int y, input logic ld, input int sh,
                      input logic clr, input logic rst);
    logic [OUT_W:0] e;
    i_valid      = v;
    i_y_n        = IN_W'(y);
    i_load_shift = ld;
    i_shift      = SHIFT_W'(sh);
    i_clr_stats  = clr;
    reset        = rst;
    @(posedge clk);
    edge_n++;
    vexp = 0;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      shift_m = 0; sat_m = 0; cnt_m = 0; peak_m = 0; last_m = 0;
    end else begin
      if (clr) begin
        sat_m = 0; cnt_m = 0; peak_m = 0;
      end
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        vexp   = 1;
        last_m = int'(e[OUT_W-1:0]);
        if (e[OUT_W]) begin
          sat_m = 1;
          if (cnt_m < 255) cnt_m++;
        end
        if (last_m > peak_m) peak_m = last_m;
      end
      if (v) begin
        exp_q.push_back(model_out(y, shift_m));
        due_q.push_back(edge_n + 1);
      end
      if (ld) shift_m = sh;
    end
    @(negedge clk);
    check("o_valid", 32'(o_valid), 32'(vexp));
    check("o_data", 32'(o_data), 32'(last_m));
    check("o_sat", 32'(o_sat), 32'(sat_m));
    check("o_sat_cnt", 32'(o_sat_cnt), 32'(cnt_m));
`ifdef FIR_OUT_PEAK_EN
    check("o_peak", 32'(o_peak), 32'(peak_m));
`else
    check("o_peak", 32'(o_peak), 32'd0);
`endif
  endtask

  task automatic send(input int y);
    step(1'b1, y, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic load_shift(input int s);
    step(1'b0, 0, 1'b1, s, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; i_valid = 1'b0; i_y_n = '0; i_shift = '0;
    i_load_shift = 1'b0; i_clr_stats = 1'b0;

    do_reset(2);

    // Basic pass-through at shift 0, then saturation, then a value below the clip.
    send(200); idle(3);
    check("tp_data_200", 32'(o_data), 32'd200);
    send(300); idle(2);
    check("tp_sat_300", 32'(o_sat), 32'd1);
    send(100); idle(3);

    // Rounding and the worst case at each shift amount.
    load_shift(1); send(5);    idle(2);
    check("tp_round_5", 32'(o_data), 32'd3);
    load_shift(2); send(1021); idle(2);
    load_shift(2); send(1023); idle(2);
    load_shift(3); send(2047); idle(2);
    check("tp_worst_2047", 32'(o_data), 32'd255);

    // A shift change while samples are in flight: the second sample still uses the old shift.
    load_shift(0);
    send(400);
    step(1'b1, 400, 1'b1, 2, 1'b0, 1'b0);
    send(400);
    idle(3);
    check("tp_inflight_3rd", 32'(o_data), 32'd100);

    // Counter saturation, then a clear with no output in flight.
    load_shift(0);
    for (int i = 0; i < 300; i++) send(300);
    idle(3);
    check("tp_cnt_hold", 32'(o_sat_cnt), 32'd255);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    check("tp_clr_cnt", 32'(o_sat_cnt), 32'd0);
    check("tp_clr_sat", 32'(o_sat), 32'd0);

    // A clear on the same cycle as a valid output.
    send(250); send(10);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    idle(2);

    // Bubbles, then a reset while samples are in flight.
    send(7); idle(1); send(9); idle(3);
    send(60); send(70);
    do_reset(1);
    check("tp_rst_valid", 32'(o_valid), 32'd0);
    idle(3);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      int y;
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(1900, 2047) : $urandom_range(0, 2047);
      step(logic'($urandom_range(0, 9) < 7), y,
           logic'($urandom_range(0, 9) == 0), $urandom_range(0, 3),
           logic'($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 199) == 0));
    end
    idle(4);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
